// File: rtl/data_bus_master.sv
// Data-bus initiator: turns one MEM-stage load/store into a single held bus transaction
// and returns aligned, extended load data (or an error) as a one-cycle response.
module data_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_mask,
  output logic [31:0] bus_data_wr,
  input  logic [31:0] bus_data_rd,
  input  logic        bus_stall
);

  typedef enum logic [1:0] {StIdle, StAccess, StErr} state_e;

  state_e      state_q, state_d;
  logic [1:0]  offset_q, offset_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] bus_address_q, bus_address_d;
  logic        bus_read_q, bus_read_d;
  logic        bus_write_q, bus_write_d;
  logic [3:0]  bus_mask_q, bus_mask_d;
  logic [31:0] bus_data_wr_q, bus_data_wr_d;

  logic        accept;
  logic        illegal;
  logic        timeout_hit;
  logic [3:0]  mask_req;
  logic [31:0] wdata_req;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;

  // Request decode: legality, byte enables and lane-replicated store data.
  always_comb begin
    illegal   = 1'b0;
    mask_req  = 4'b0000;
    wdata_req = 32'h0;
    case (req_size)
      2'd0: begin
        mask_req  = 4'b0001 << req_addr[1:0];
        wdata_req = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        illegal   = req_addr[0];
        mask_req  = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_req = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        illegal   = |req_addr[1:0];
        mask_req  = 4'b1111;
        wdata_req = req_wdata;
      end
      default: illegal = 1'b1;
    endcase
    if (!req_write) wdata_req = 32'h0;
  end

  assign shifted = bus_data_rd >> {offset_q, 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    load_ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Fires on the stalled cycle that would bring the stall count up to the limit.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d       = state_q;
    offset_d      = offset_q;
    size_d        = size_q;
    signed_d      = signed_q;
    cnt_d         = cnt_q;
    bus_address_d = bus_address_q;
    bus_read_d    = bus_read_q;
    bus_write_d   = bus_write_q;
    bus_mask_d    = bus_mask_q;
    bus_data_wr_d = bus_data_wr_q;
    resp_valid_d  = 1'b0;
    resp_error_d  = 1'b0;
    resp_rdata_d  = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          offset_d = req_addr[1:0];
          size_d   = req_size;
          signed_d = req_signed;
          cnt_d    = 32'h0;
          if (illegal) begin
            state_d = StErr;
          end else begin
            state_d       = StAccess;
            bus_address_d = {req_addr[31:2], 2'b00};
            bus_read_d    = ~req_write;
            bus_write_d   = req_write;
            bus_mask_d    = mask_req;
            bus_data_wr_d = wdata_req;
          end
        end
      end
      StAccess: begin
        if (!bus_stall || timeout_hit) begin
          state_d       = StIdle;
          bus_address_d = 32'h0;
          bus_read_d    = 1'b0;
          bus_write_d   = 1'b0;
          bus_mask_d    = 4'b0000;
          bus_data_wr_d = 32'h0;
          resp_valid_d  = 1'b1;
          if (bus_stall) begin
            resp_error_d = 1'b1;
          end else if (bus_read_q) begin
            resp_rdata_d = load_ext;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StErr: begin
        state_d      = StIdle;
        resp_valid_d = 1'b1;
        resp_error_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      offset_q      <= 2'b00;
      size_q        <= 2'b00;
      signed_q      <= 1'b0;
      cnt_q         <= 32'h0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
      bus_address_q <= 32'h0;
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
      bus_mask_q    <= 4'b0000;
      bus_data_wr_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      offset_q      <= offset_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      cnt_q         <= cnt_d;
      resp_valid_q  <= resp_valid_d;
      resp_error_q  <= resp_error_d;
      resp_rdata_q  <= resp_rdata_d;
      bus_address_q <= bus_address_d;
      bus_read_q    <= bus_read_d;
      bus_write_q   <= bus_write_d;
      bus_mask_q    <= bus_mask_d;
      bus_data_wr_q <= bus_data_wr_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_error  = resp_error_q;
  assign resp_rdata  = resp_rdata_q;
  assign bus_address = bus_address_q;
  assign bus_read    = bus_read_q;
  assign bus_write   = bus_write_q;
  assign bus_mask    = bus_mask_q;
  assign bus_data_wr = bus_data_wr_q;

endmodule

// File: tb/tb_data_bus_master.sv
// Bench for data_bus_master: responder with word memory, byte-level reference model,
// directed vector table, timeout/reset/back-to-back sequences and randomized requests.
module tb_data_bus_master;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wd;
    logic        bus_act;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] bus_address, bus_data_wr, bus_data_rd;
  logic        bus_read, bus_write, bus_stall;
  logic [3:0]  bus_mask;

  int errors = 0;
  int checks = 0;
  int rd_stall = 1;
  int rd_cnt = 0;
  bit stall_force = 1'b0;
  bit [31:0] mem [256];
  bit [7:0]  ref_mem [1024];
  vec_t tbl [9];

  data_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error),
    .bus_address (bus_address),
    .bus_read    (bus_read),
    .bus_write   (bus_write),
    .bus_mask    (bus_mask),
    .bus_data_wr (bus_data_wr),
    .bus_data_rd (bus_data_rd),
    .bus_stall   (bus_stall)
  );

  always #5 clk = ~clk;

  // Responder: reads stall rd_stall cycles, writes never stall unless forced.
  always_comb begin
    bus_stall   = stall_force | (bus_read & (rd_cnt < rd_stall));
    bus_data_rd = mem[bus_address[9:2]];
  end

  always @(posedge clk) begin
    if (bus_read && bus_stall) rd_cnt <= rd_cnt + 1;
    else rd_cnt <= 0;
    if (bus_write && !bus_stall)
      for (int i = 0; i < 4; i++)
        if (bus_mask[i]) mem[bus_address[9:2]][8*i +: 8] <= bus_data_wr[8*i +: 8];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata,
                              input logic [3:0] mask, input logic [31:0] wd, input int lat);
    vec_t r;
    r.wr = wr; r.size = size; r.sgn = sgn; r.addr = addr; r.wdata = wdata;
    r.exp_err = err; r.exp_rdata = rdata; r.exp_mask = mask; r.exp_wd = wd;
    r.bus_act = !err; r.exp_lat = lat;
    return r;
  endfunction

  // Reference model on a byte-addressed memory; also updates that memory for stores.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int unsigned nb, a;
    longint val;
    logic [31:0] tmp;
    bit ill;
    r = v;
    a = v.addr;
    nb = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    ill = (v.size == 2'd3) || ((a % nb) != 0);
    r.exp_err = ill;
    r.bus_act = !ill;
    r.exp_rdata = 32'h0;
    r.exp_mask = 4'h0;
    r.exp_wd = 32'h0;
    r.exp_lat = (ill || v.wr) ? 2 : rd_stall + 2;
    if (!ill) begin
      for (int unsigned k = 0; k < nb; k++) r.exp_mask = r.exp_mask | (4'b0001 << ((a + k) % 4));
      if (v.wr) begin
        for (int unsigned lane = 0; lane < 4; lane++) begin
          tmp = (v.wdata >> (8 * (lane % nb))) & 32'hFF;
          r.exp_wd = r.exp_wd | (tmp << (8 * lane));
        end
        for (int unsigned k = 0; k < nb; k++)
          ref_mem[(a + k) % 1024] = 8'((v.wdata >> (8 * k)) & 32'hFF);
      end else begin
        val = 0;
        for (int unsigned k = 0; k < nb; k++)
          val = val | (longint'(ref_mem[(a + k) % 1024]) << (8 * k));
        if (v.sgn && (((val >> (8 * nb - 1)) & 1) != 0)) val = val - (longint'(1) << (8 * nb));
        r.exp_rdata = 32'(val);
      end
    end
    return r;
  endfunction

  task automatic do_req(input vec_t v);
    int lat, act, waited;
    bit bad_idle, unstable;
    logic [31:0] a0, d0;
    logic [3:0] m0;
    logic r0, w0;
    lat = 1; act = 0; waited = 0; bad_idle = 0; unstable = 0;
    a0 = 0; d0 = 0; m0 = 0; r0 = 0; w0 = 0;
    req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", req_ready, 1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_signed = 1'($urandom);
    while (!resp_valid && lat < 40) begin
      if (v.bus_act) begin
        if (bus_read || bus_write) act++;
        if (lat == 1) begin
          a0 = bus_address; d0 = bus_data_wr; m0 = bus_mask; r0 = bus_read; w0 = bus_write;
        end else if (bus_address !== a0 || bus_data_wr !== d0 || bus_mask !== m0 ||
                     bus_read !== r0 || bus_write !== w0) begin
          unstable = 1;
        end
      end else if (bus_read || bus_write) begin
        bad_idle = 1;
      end
      @(negedge clk);
      lat++;
    end
    check("resp_valid", resp_valid, 1);
    check("latency", lat, v.exp_lat);
    check("resp_error", resp_error, v.exp_err);
    check("resp_rdata", resp_rdata, v.exp_rdata);
    check("ready_at_resp", req_ready, 1);
    check("bus_idle_at_resp", {bus_read, bus_write}, 0);
    if (v.bus_act) begin
      check("bus_rw", {r0, w0}, {~v.wr, v.wr});
      check("bus_address", a0, {v.addr[31:2], 2'b00});
      check("bus_mask", m0, v.exp_mask);
      check("bus_data_wr", d0, v.exp_wd);
      check("bus_active_cycles", act, v.exp_lat - 1);
      check("bus_stable", unstable, 0);
    end else begin
      check("no_bus_on_error", bad_idle, 0);
    end
  endtask

  initial begin
    vec_t v, tmp;
    bit seen;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;

    tbl[0] = mk(1, 2'd0, 0, 32'h103, 32'h000000A5, 0, 32'h0, 4'b1000, 32'hA5A5A5A5, 2);
    tbl[1] = mk(0, 2'd2, 0, 32'h100, 32'h0, 0, 32'hA5000000, 4'b1111, 32'h0, 3);
    tbl[2] = mk(1, 2'd2, 0, 32'h200, 32'h8000FF80, 0, 32'h0, 4'b1111, 32'h8000FF80, 2);
    tbl[3] = mk(0, 2'd1, 1, 32'h200, 32'h0, 0, 32'hFFFFFF80, 4'b0011, 32'h0, 3);
    tbl[4] = mk(0, 2'd1, 0, 32'h202, 32'h0, 0, 32'h00008000, 4'b1100, 32'h0, 3);
    tbl[5] = mk(0, 2'd0, 1, 32'h201, 32'h0, 0, 32'hFFFFFFFF, 4'b0010, 32'h0, 3);
    tbl[6] = mk(0, 2'd2, 0, 32'h102, 32'h0, 1, 32'h0, 4'b0000, 32'h0, 2);
    tbl[7] = mk(1, 2'd1, 0, 32'h001, 32'h1234, 1, 32'h0, 4'b0000, 32'h0, 2);
    tbl[8] = mk(0, 2'd3, 0, 32'h300, 32'h0, 1, 32'h0, 4'b0000, 32'h0, 2);

    repeat (3) @(negedge clk);
    check("rst_bus_rw", {bus_read, bus_write}, 0);
    check("rst_resp_valid", resp_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_resp", {resp_valid, resp_error}, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_address", bus_address, 0);
    check("rst_mask", bus_mask, 0);
    check("rst_wdata", bus_data_wr, 0);

    rd_stall = 1;
    for (int i = 0; i < 9; i++) begin
      tmp = model(tbl[i]);
      do_req(tbl[i]);
    end

    // Timeout: responder never releases a load.
    stall_force = 1'b1;
    v = mk(0, 2'd2, 0, 32'h100, 32'h0, 1, 32'h0, 4'b1111, 32'h0, 5);
    v.bus_act = 1'b1;
    do_req(v);
    stall_force = 1'b0;

    // Reset in the middle of a stalled read.
    stall_force = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h104;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_reset_read", bus_read, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_drops_read", bus_read, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stall_force = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    check("no_resp_after_reset", seen, 0);
    check("ready_after_reset", req_ready, 1);
    v.wr = 0; v.size = 2'd2; v.sgn = 0; v.addr = 32'h100; v.wdata = 0;
    do_req(model(v));

    // Back-to-back stores with req_valid held high.
    for (int k = 0; k < 4; k++) begin
      v.wr = 1; v.size = 2'd2; v.sgn = 0; v.addr = 32'h380 + 32'(4 * k); v.wdata = $urandom;
      v = model(v);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
      req_addr = v.addr; req_wdata = v.wdata;
      if (k > 0) check("b2b_resp_and_ready", {resp_valid, req_ready}, 2'b11);
      else check("b2b_first_ready", req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      check("b2b_bus_write", {bus_write, req_ready}, 2'b10);
      check("b2b_data", bus_data_wr, v.exp_wd);
      @(negedge clk);
    end
    check("b2b_last_resp", resp_valid, 1);
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v.wr = 0; v.size = 2'd2; v.sgn = 0; v.addr = 32'h380 + 32'(4 * k); v.wdata = 0;
      do_req(model(v));
    end

    // Randomized requests against the reference model.
    for (int n = 0; n < 40; n++) begin
      rd_stall = int'($urandom_range(0, 3));
      v.wr = 1'($urandom);
      v.size = 2'($urandom);
      v.sgn = 1'($urandom);
      v.addr = 32'($urandom_range(0, 1023));
      v.wdata = $urandom;
      do_req(model(v));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
